spi_slave_if: RTL and testbench

SPI target-side (slave) byte interface: the receiving end of the serial link whose master clock is produced by the SPI baud generator. It synchronises external `spi_cs_n`, `spi_sclk` and `spi_mosi` into `clk_sys`, deserialises MOSI bytes, and serialises reply bytes onto MISO. The block supports SPI mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit words. It sits between the board-level SPI pins and the register/command logic in the `clk_sys` domain.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 45 ++++
 rtl/spi_slave_if.sv | 176 +++++++++++++++++
 tb/tb_spi_slave_if.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI target-side (slave) byte interface.
//   SPI_WORD_W  : bits per SPI word (MSB first).
//   SPI_BCNT_W  : width of the in-byte bit counter.
//   spi_state_e : frame state, idle (0) or active (1).
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 8;
    localparam int unsigned SPI_BCNT_W = 3;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// spi_sync_edge
// Two-flop synchroniser for an asynchronous pin, followed by a history flop
// used to detect edges of the synchronised value.
// Ports:
//   clk_sys : system clock.
//   rst_n   : asynchronous active-low reset; all three flops reset to ResetVal.
//   din     : asynchronous input pin.
//   sync    : synchronised level.
//   rise    : synchronised value went 0 -> 1 (sync == 1, history == 0).
//   fall    : synchronised value went 1 -> 0 (sync == 0, history == 1).
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            hist_q <= ResetVal;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~hist_q;
    assign fall = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_if.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// spi_slave_if
// SPI mode-0 target-side byte interface, MSB first, 8-bit words. The pins are
// oversampled in clk_sys (at least 8x sclk); MOSI bytes are deserialised on
// sclk rising edges and reply bytes are shifted onto MISO on falling edges.
// Ports:
//   clk_sys      : system clock.
//   rst_n        : asynchronous active-low reset.
//   spi_cs_n     : chip select from master, active-low, asynchronous.
//   spi_sclk     : serial clock from master, asynchronous.
//   spi_mosi     : serial data from master.
//   spi_miso     : serial data to master, 0 outside a frame.
//   tx_data      : next reply byte, captured on the tx_load cycle.
//   tx_load      : one-cycle pulse, tx_data captured this cycle.
//   rx_data      : last complete received byte, held until the next one.
//   rx_valid     : one-cycle pulse, rx_data updated.
//   frame_active : high while a frame is in progress.
//   frame_end    : one-cycle pulse when the synchronised cs_n rises.
//   frame_err    : pulses with frame_end when the frame ended mid-byte.
// -----------------------------------------------------------------------------
module spi_slave_if
    import spi_pkg::*;
(
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic                  tx_load,
    output logic [SPI_WORD_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_active,
    output logic                  frame_end,
    output logic                  frame_err
);

    localparam logic [SPI_BCNT_W-1:0] BcntOne  = SPI_BCNT_W'(1);
    localparam logic [SPI_BCNT_W-1:0] BcntLast = SPI_BCNT_W'(SPI_WORD_W - 1);
    localparam logic [1:0]            WarmDone = 2'd2;

    // Synchronised pin views
    logic cs_sync;
    logic cs_rise;
    logic cs_fall;
    logic sclk_sync_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic mosi_sync;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_sync_edge #(
        .ResetVal (1'b1)
    ) u_sync_cs (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (spi_cs_n),
        .sync    (cs_sync),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    spi_sync_edge #(
        .ResetVal (1'b0)
    ) u_sync_sclk (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (spi_sclk),
        .sync    (sclk_sync_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_sync_edge #(
        .ResetVal (1'b0)
    ) u_sync_mosi (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .din     (spi_mosi),
        .sync    (mosi_sync),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    // Frame state
    spi_state_e            state_q;
    logic                  armed_q;
    logic [1:0]            warm_q;
    logic                  started_q;
    logic [SPI_BCNT_W-1:0] bit_cnt_q;
    logic [SPI_WORD_W-1:0] rx_shift_q;
    logic [SPI_WORD_W-1:0] tx_shift_q;

    // The cs_n synchroniser resets to 1, so for the first two cycles after
    // reset its output is the reset value rather than the pin. warm_q holds off
    // arming until the synchronised level reflects the real pin; otherwise a
    // cs_n already low at reset release would look like a genuine frame start.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            armed_q      <= 1'b0;
            warm_q       <= 2'd0;
            started_q    <= 1'b0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            spi_miso     <= 1'b0;
            tx_load      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            tx_load   <= 1'b0;
            rx_valid  <= 1'b0;
            frame_end <= 1'b0;
            frame_err <= 1'b0;

            if (warm_q != WarmDone) begin
                warm_q <= warm_q + 2'd1;
            end
            if ((warm_q == WarmDone) && cs_sync) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    // Same-cycle sclk edges are dropped: only the start counts.
                    if (cs_fall && armed_q) begin
                        state_q      <= StActive;
                        frame_active <= 1'b1;
                        started_q    <= 1'b0;
                        bit_cnt_q    <= '0;
                        tx_shift_q   <= tx_data;
                        spi_miso     <= tx_data[SPI_WORD_W-1];
                        tx_load      <= 1'b1;
                    end
                end
                StActive: begin
                    if (cs_rise) begin
                        // Frame end wins over any sclk edge in the same cycle;
                        // a partial byte is dropped without rx_valid.
                        state_q      <= StIdle;
                        frame_active <= 1'b0;
                        spi_miso     <= 1'b0;
                        frame_end    <= 1'b1;
                        frame_err    <= (bit_cnt_q != '0);
                    end else if (sclk_rise) begin
                        started_q  <= 1'b1;
                        rx_shift_q <= {rx_shift_q[SPI_WORD_W-2:0], mosi_sync};
                        bit_cnt_q  <= bit_cnt_q + BcntOne;
                        if (bit_cnt_q == BcntLast) begin
                            rx_data  <= {rx_shift_q[SPI_WORD_W-2:0], mosi_sync};
                            rx_valid <= 1'b1;
                        end
                    end else if (sclk_fall && started_q) begin
                        if (bit_cnt_q == '0) begin
                            // Byte boundary: next reply byte goes out MSB first.
                            tx_shift_q <= tx_data;
                            spi_miso   <= tx_data[SPI_WORD_W-1];
                            tx_load    <= 1'b1;
                        end else begin
                            tx_shift_q <= {tx_shift_q[SPI_WORD_W-2:0], 1'b0};
                            spi_miso   <= tx_shift_q[SPI_WORD_W-2];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_spi_slave_if
// Bench acting as SPI master (mode 0, 5 MHz sclk against 50 MHz clk_sys).
// Expected values come from a frame-level model: complete MOSI bytes in order,
// reply bytes consumed one per byte boundary, pulse counts per frame.
// -----------------------------------------------------------------------------
module tb_spi_slave_if;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       spi_cs_n;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_active;
    logic       frame_end;
    logic       frame_err;

    int n_checks = 0;
    int n_errs   = 0;

    // Reply byte source and monitor tallies
    logic [7:0] tx_mem [0:255];
    int         tx_ptr   = 0;
    logic [7:0] rx_got [$];
    int         n_txload = 0;
    int         n_fend   = 0;
    int         n_ferr   = 0;
    int         n_fa     = 0;
    logic       prev_rv  = 1'b0;
    logic [7:0] last_rx  = 8'h00;

    always #10 clk_sys = ~clk_sys;

    spi_slave_if dut (
        .clk_sys      (clk_sys),
        .rst_n        (rst_n),
        .spi_cs_n     (spi_cs_n),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .tx_data      (tx_data),
        .tx_load      (tx_load),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_active (frame_active),
        .frame_end    (frame_end),
        .frame_err    (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Per-cycle monitor, sampled on the falling clk_sys edge
    initial begin
        forever begin
            @(negedge clk_sys);
            if (rx_valid === 1'b1) begin
                rx_got.push_back(rx_data);
                check("rv_gap", {31'd0, prev_rv}, 32'd0);
            end
            prev_rv = rx_valid;
            if (tx_load === 1'b1) begin
                tx_ptr = (tx_ptr + 1) % 256;
                n_txload++;
            end
            tx_data = tx_mem[tx_ptr];
            if (frame_end === 1'b1) n_fend++;
            if (frame_err === 1'b1) begin
                n_ferr++;
                check("err_with_end", {31'd0, frame_end}, 32'd1);
            end
            if (frame_active === 1'b1) n_fa++;
            else check("miso_idle", {31'd0, spi_miso}, 32'd0);
        end
    end

    // Half an sclk period; pin changes land 1 ns before a clk_sys rising edge.
    task automatic half();
        repeat (5) @(posedge clk_sys);
        #19;
    endtask

    // One master frame of nbits bits taken MSB-first from data[31:...].
    // abort_rise raises cs_n together with one extra sclk rise at the end.
    // lat_chk times rx_valid against the 8th sclk rise.
    task automatic xfer(input int nbits, input logic [31:0] data, input bit abort_rise,
                        input bit lat_chk);
        int          p0;
        int          rv0;
        int          tl0;
        int          fe0;
        int          fr0;
        int          nbytes;
        logic [31:0] got_miso;
        logic [31:0] exp_miso;
        logic [7:0]  exp_byte;
        p0       = tx_ptr;
        rv0      = rx_got.size();
        tl0      = n_txload;
        fe0      = n_fend;
        fr0      = n_ferr;
        got_miso = '0;
        exp_miso = '0;
        spi_cs_n = 1'b0;
        spi_mosi = data[31];
        half();
        check("frame_active", {31'd0, frame_active}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            exp_byte          = tx_mem[(p0 + i / 8) % 256];
            got_miso[31 - i]  = spi_miso;
            exp_miso[31 - i]  = exp_byte[7 - (i % 8)];
            spi_sclk          = 1'b1;
            if (lat_chk && i == 7) begin
                @(posedge clk_sys);
                @(posedge clk_sys);
                #1 check("lat_edge2", {31'd0, rx_valid}, 32'd0);
                @(posedge clk_sys);
                #1 check("lat_edge3", {31'd0, rx_valid}, 32'd1);
                repeat (2) @(posedge clk_sys);
                #19;
            end else begin
                half();
            end
            spi_sclk = 1'b0;
            if (i + 1 < nbits) spi_mosi = data[31 - (i + 1)];
            half();
        end
        if (abort_rise) begin
            spi_sclk = 1'b1;
            spi_cs_n = 1'b1;
            half();
            spi_sclk = 1'b0;
        end else begin
            spi_cs_n = 1'b1;
        end
        half();
        half();
        nbytes = nbits / 8;
        check("rx_count", rx_got.size() - rv0, nbytes);
        for (int j = 0; j < nbytes; j++) begin
            exp_byte = data[31 - 8 * j -: 8];
            if (rv0 + j < rx_got.size()) check("rx_byte", {24'd0, rx_got[rv0 + j]}, {24'd0, exp_byte});
            last_rx = exp_byte;
        end
        check("rx_hold", {24'd0, rx_data}, {24'd0, last_rx});
        check("miso_bits", got_miso, exp_miso);
        check("tx_load_cnt", n_txload - tl0, 1 + nbytes);
        check("frame_end_cnt", n_fend - fe0, 1);
        check("frame_err_cnt", n_ferr - fr0, (nbits % 8 != 0) ? 1 : 0);
        check("frame_idle", {31'd0, frame_active}, 32'd0);
    endtask

    initial begin
        int rv0;
        int tl0;
        int fa0;
        int nb;
        for (int k = 0; k < 256; k++) tx_mem[k] = 8'($urandom);
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(posedge clk_sys);
        #5;
        check("rst_miso", {31'd0, spi_miso}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_load", {31'd0, tx_load}, 32'd0);
        check("rst_frame_active", {31'd0, frame_active}, 32'd0);
        check("rst_frame_end", {31'd0, frame_end}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        @(posedge clk_sys);
        #19;
        rst_n = 1'b1;
        // Directed 2-byte frame with set replies, plus rx_valid latency
        tx_mem[tx_ptr]                 = 8'h81;
        tx_mem[(tx_ptr + 1) % 256]     = 8'hF0;
        half();
        half();
        xfer(16, 32'hA53C_0000, 1'b0, 1'b1);

        // cs_n rises after 5 bits
        xfer(5, $urandom, 1'b0, 1'b0);

        // cs_n rises together with the 8th sclk rise
        xfer(7, $urandom, 1'b1, 1'b0);

        // Reset released while cs_n low and mid-byte
        rv0      = rx_got.size();
        tl0      = n_txload;
        rst_n    = 1'b0;
        last_rx  = 8'h00;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) rst_n = 1'b1;
            spi_mosi = 1'($urandom);
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
            half();
        end
        fa0 = n_fa;
        half();
        check("rst_mid_active", {31'd0, frame_active}, 32'd0);
        check("rst_mid_fa_cycles", n_fa - fa0, 0);
        check("rst_mid_rx", rx_got.size() - rv0, 0);
        check("rst_mid_tx_load", n_txload - tl0, 0);
        spi_cs_n = 1'b1;
        half();
        half();
        xfer(8, 32'h5A00_0000, 1'b0, 1'b0);

        // sclk toggling with cs_n idle high
        rv0 = rx_got.size();
        tl0 = n_txload;
        fa0 = n_fa;
        for (int i = 0; i < 16; i++) begin
            spi_mosi = 1'($urandom);
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
            half();
        end
        check("idle_rx", rx_got.size() - rv0, 0);
        check("idle_tx_load", n_txload - tl0, 0);
        check("idle_fa_cycles", n_fa - fa0, 0);
        check("idle_miso", {31'd0, spi_miso}, 32'd0);

        // Randomised frames
        for (int f = 0; f < 12; f++) begin
            nb = int'($urandom_range(1, 32));
            xfer(nb, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
